// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command codes, arbiter states and pick indices.
package sdram_pkg;

    // Commands are {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CmdNop       = 4'b0111;
    localparam logic [3:0] CmdPrecharge = 4'b0010;
    localparam logic [3:0] CmdAref      = 4'b0001;
    localparam logic [3:0] CmdActive    = 4'b0011;
    localparam logic [3:0] CmdWrite     = 4'b0100;
    localparam logic [3:0] CmdRead      = 4'b0101;
    localparam logic [3:0] CmdMrs       = 4'b0000;

    typedef enum logic [2:0] {
        StIdle,
        StArbit,
        StAref,
        StWrite,
        StRead
    } arb_state_e;

    localparam int unsigned PickW   = 3;
    localparam int unsigned PickRef = 0;
    localparam int unsigned PickWr  = 1;
    localparam int unsigned PickRd  = 2;

endpackage

// File: rtl/sdram_arbit_pick.sv
// Combinational request picker: refresh first, then write/read (alternating when
// SDRAM_ARBIT_RR_EN is defined, write-first otherwise). Output is one-hot or zero.
module sdram_arbit_pick
    import sdram_pkg::*;
(
    input  logic             ref_req,
    input  logic             wr_req,
    input  logic             rd_req,
`ifdef SDRAM_ARBIT_RR_EN
    input  logic             last_wr,
`endif
    output logic [PickW-1:0] pick
);

    logic wr_first;

`ifdef SDRAM_ARBIT_RR_EN
    assign wr_first = ~last_wr;
`else
    assign wr_first = 1'b1;
`endif

    always_comb begin
        pick = '0;
        if (ref_req) begin
            pick[PickRef] = 1'b1;
        end else if (wr_req && (wr_first || !rd_req)) begin
            pick[PickWr] = 1'b1;
        end else if (rd_req) begin
            pick[PickRd] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter between init, auto-refresh, write and read engines.
// Optional round-robin write/read fairness via SDRAM_ARBIT_RR_EN.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned BA_W   = 2,
    parameter int unsigned CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_init_end,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              flag_ref_end,
    input  logic [CMD_W-1:0]  aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              flag_wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic              rd_req,
    input  logic              flag_rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              ref_pend,
    output logic              sdram_cke,
    output logic [CMD_W-1:0]  sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba
);

    arb_state_e        state_q, state_d;
    logic [PickW-1:0]  pick;
    logic              ref_en_q, wr_en_q, rd_en_q;
    logic              ref_en_d, wr_en_d, rd_en_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BA_W-1:0]   ba_q, ba_d;

`ifdef SDRAM_ARBIT_RR_EN
    logic last_wr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q <= 1'b0;
        end else if (state_q == StArbit) begin
            if (pick[PickWr]) begin
                last_wr_q <= 1'b1;
            end else if (pick[PickRd]) begin
                last_wr_q <= 1'b0;
            end
        end
    end
`endif

    sdram_arbit_pick u_pick (
        .ref_req (ref_req),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
`ifdef SDRAM_ARBIT_RR_EN
        .last_wr (last_wr_q),
`endif
        .pick    (pick)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (flag_init_end) state_d = StArbit;
            StArbit: begin
                if (pick[PickRef]) begin
                    state_d = StAref;
                end else if (pick[PickWr]) begin
                    state_d = StWrite;
                end else if (pick[PickRd]) begin
                    state_d = StRead;
                end
            end
            StAref:  if (flag_ref_end) state_d = StArbit;
            StWrite: if (flag_wr_end) state_d = StArbit;
            StRead:  if (flag_rd_end) state_d = StArbit;
            default: state_d = StIdle;
        endcase
    end

    // Grant pulses fire only on the ARBIT->X edge, so one request yields one pulse.
    always_comb begin
        ref_en_d = (state_q == StArbit) && pick[PickRef];
        wr_en_d  = (state_q == StArbit) && pick[PickWr];
        rd_en_d  = (state_q == StArbit) && pick[PickRd];
    end

    always_comb begin
        cmd_d  = CMD_W'(CmdNop);
        addr_d = '0;
        ba_d   = '0;
        unique case (state_q)
            StIdle: begin
                cmd_d  = init_cmd;
                addr_d = init_addr;
            end
            StAref: begin
                cmd_d  = aref_cmd;
                addr_d = aref_addr;
            end
            StWrite: begin
                cmd_d  = wr_cmd;
                addr_d = wr_addr;
                ba_d   = wr_ba;
            end
            StRead: begin
                cmd_d  = rd_cmd;
                addr_d = rd_addr;
                ba_d   = rd_ba;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            cmd_q    <= CMD_W'(CmdNop);
            addr_q   <= '0;
            ba_q     <= '0;
        end else begin
            state_q  <= state_d;
            ref_en_q <= ref_en_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            ba_q     <= ba_d;
        end
    end

    assign ref_en     = ref_en_q;
    assign wr_en      = wr_en_q;
    assign rd_en      = rd_en_q;
    assign ref_pend   = ref_req && ((state_q == StWrite) || (state_q == StRead));
    assign sdram_cke  = 1'b1;
    assign sdram_cmd  = cmd_q;
    assign sdram_addr = addr_q;
    assign sdram_ba   = ba_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed table-driven bench for sdram_arbit plus hand sequences for reset and RR.
module tb_sdram_arbit;

    localparam logic [3:0]  NOP  = 4'b0111;
    localparam logic [3:0]  PRE  = 4'b0010;
    localparam logic [3:0]  WRC  = 4'b0100;
    localparam logic [3:0]  RDC  = 4'b0101;
    localparam logic [12:0] IADR = 13'h0400;
    localparam logic [12:0] AADR = 13'h0011;
    localparam logic [12:0] WADR = 13'h0123;
    localparam logic [12:0] RADR = 13'h0456;
    localparam logic [1:0]  WBA  = 2'b01;
    localparam logic [1:0]  RBA  = 2'b10;

    localparam int SrcNop = 0, SrcInit = 1, SrcAref = 2, SrcWr = 3, SrcRd = 4;

`ifdef SDRAM_ARBIT_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_init_end, ref_req, flag_ref_end, wr_req, flag_wr_end, rd_req, flag_rd_end;
    logic [3:0]  init_cmd;
    logic        ref_en, wr_en, rd_en, ref_pend, sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdram_arbit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flag_init_end (flag_init_end),
        .init_cmd      (init_cmd),
        .init_addr     (IADR),
        .ref_req       (ref_req),
        .flag_ref_end  (flag_ref_end),
        .aref_cmd      (PRE),
        .aref_addr     (AADR),
        .wr_req        (wr_req),
        .flag_wr_end   (flag_wr_end),
        .wr_cmd        (WRC),
        .wr_addr       (WADR),
        .wr_ba         (WBA),
        .rd_req        (rd_req),
        .flag_rd_end   (flag_rd_end),
        .rd_cmd        (RDC),
        .rd_addr       (RADR),
        .rd_ba         (RBA),
        .ref_en        (ref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .ref_pend      (ref_pend),
        .sdram_cke     (sdram_cke),
        .sdram_cmd     (sdram_cmd),
        .sdram_addr    (sdram_addr),
        .sdram_ba      (sdram_ba)
    );

    typedef struct {
        logic       ie, rq, wq, dq, re, we, de;
        logic [3:0] icmd;
        logic       e_ref, e_wr, e_rd, e_pend;
        int         src;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pins(input string tag, input int src, input logic [3:0] icmd);
        logic [3:0]  c;
        logic [12:0] a;
        logic [1:0]  b;
        c = NOP; a = '0; b = '0;
        case (src)
            SrcInit: begin c = icmd; a = IADR; end
            SrcAref: begin c = PRE;  a = AADR; end
            SrcWr:   begin c = WRC;  a = WADR; b = WBA; end
            SrcRd:   begin c = RDC;  a = RADR; b = RBA; end
            default: ;
        endcase
        check({tag, " cmd"},  32'(sdram_cmd),  32'(c));
        check({tag, " addr"}, 32'(sdram_addr), 32'(a));
        check({tag, " ba"},   32'(sdram_ba),   32'(b));
    endtask

    task automatic drive(input logic ie, rq, wq, dq, re, we, de, input logic [3:0] icmd);
        flag_init_end = ie; ref_req = rq; wr_req = wq; rd_req = dq;
        flag_ref_end = re; flag_wr_end = we; flag_rd_end = de; init_cmd = icmd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] icmds[4];
        icmds[0] = 4'b0000; icmds[1] = 4'b0001; icmds[2] = 4'b0011; icmds[3] = 4'b0110;

        //          ie rq wq dq re we de icmd     ref wr rd pend src
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, SrcInit};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, SrcNop};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, SrcAref};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, SrcAref};
        vecs[4]  = '{0, 1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0, 0, SrcNop};
        vecs[5]  = '{0, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, SrcAref};
        vecs[6]  = '{0, 0, 1, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, SrcAref};
        vecs[7]  = '{0, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 1, 0, 0, SrcNop};
        vecs[8]  = '{0, 1, 0, 1, 0, 0, 1, 4'b0000, 0, 0, 0, 1, SrcWr};
        vecs[9]  = '{0, 1, 0, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, SrcWr};
        vecs[10] = '{0, 1, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 0, 0, SrcNop};
        vecs[11] = '{0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, SrcAref};
        vecs[12] = '{0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 1, 0, SrcNop};
        vecs[13] = '{0, 1, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 1, SrcRd};
        vecs[14] = '{0, 1, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, SrcRd};
        vecs[15] = '{0, 1, 1, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, SrcNop};
        vecs[16] = '{0, 0, 1, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, SrcAref};
        vecs[17] = '{0, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0, SrcNop};
        vecs[18] = '{0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, SrcWr};
        vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, SrcNop};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 4'b0000);
        repeat (3) tick();
        check("reset ref_en", 32'(ref_en), 0);
        check("reset wr_en", 32'(wr_en), 0);
        check("reset rd_en", 32'(rd_en), 0);
        check("reset ref_pend", 32'(ref_pend), 0);
        check("reset cke", 32'(sdram_cke), 1);
        check_pins("reset", SrcNop, 4'b0000);
        rst_n = 1'b1;

        // Waiting for init: pins echo init engine, requests are not granted.
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0, icmds[i % 4]);
            tick();
            check_pins("init echo", SrcInit, icmds[i % 4]);
            check("init no wr_en", 32'(wr_en), 0);
        end

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].ie, vecs[i].rq, vecs[i].wq, vecs[i].dq,
                  vecs[i].re, vecs[i].we, vecs[i].de, vecs[i].icmd);
            tick();
            check($sformatf("vec%0d ref_en", i), 32'(ref_en), 32'(vecs[i].e_ref));
            check($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr));
            check($sformatf("vec%0d rd_en", i), 32'(rd_en), 32'(vecs[i].e_rd));
            check($sformatf("vec%0d ref_pend", i), 32'(ref_pend), 32'(vecs[i].e_pend));
            check_pins($sformatf("vec%0d", i), vecs[i].src, vecs[i].icmd);
        end

        // Asynchronous reset in the middle of a read.
        drive(0, 0, 0, 1, 0, 0, 0, 4'b0000);
        tick();
        check("rd grant", 32'(rd_en), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 4'b0000);
        tick();
        check_pins("read pins", SrcRd, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        check_pins("async reset", SrcNop, 4'b0000);
        check("async reset rd_en", 32'(rd_en), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 0, 0, 0, 4'b0011);
            tick();
            check("post-reset no wr_en", 32'(wr_en), 0);
            check("post-reset no rd_en", 32'(rd_en), 0);
            check_pins("post-reset", SrcInit, 4'b0011);
        end

        // Write and read held high together.
        drive(1, 0, 1, 1, 0, 0, 0, 4'b0011);
        tick();
        for (int g = 0; g < 4; g++) begin
            logic exp_wr;
            exp_wr = RrEn ? ((g % 2) == 0) : 1'b1;
            drive(0, 0, 1, 1, 0, 0, 0, 4'b0000);
            tick();
            check($sformatf("grant%0d wr_en", g), 32'(wr_en), 32'(exp_wr));
            check($sformatf("grant%0d rd_en", g), 32'(rd_en), 32'(!exp_wr));
            drive(0, 0, 1, 1, 0, exp_wr, !exp_wr, 4'b0000);
            tick();
            check($sformatf("burst%0d pins", g), 32'(sdram_cmd), 32'(exp_wr ? WRC : RDC));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
